// File: rtl/dbg_halt_sched.sv
// Debug halt scheduler: merges the debug module request with a bus-programmed timed halt window.
// Define DBG_HALT_SCHED_IRQ_EN to add irq_o and the CTRL.IE bit.
module dbg_halt_sched #(
  parameter int unsigned AckTimeout = 1024,
  parameter int unsigned CntWidth   = 32
) (
  input  logic        IO_CLK,
  input  logic        IO_RST_N,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        dm_debug_req_i,
  input  logic        core_debug_mode_i,
`ifdef DBG_HALT_SCHED_IRQ_EN
  output logic        irq_o,
`endif
  output logic        debug_req_o
);

  // state | meaning
  // IDLE  | no window active
  // DELAY | counting down START before asserting debug_req
  // ASSERT| debug_req forced, waiting for the core to ack (bounded by AckTimeout)
  // HOLD  | core halted, counting down DURATION before release
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ASSERT = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [CntWidth-1:0] AckLast = CntWidth'(AckTimeout - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] start_q, start_d, duration_q, duration_d;
  logic                pass_dm_q, pass_dm_d, ie_q;
  logic                done_q, done_d, timeout_q, timeout_d;
  logic                rvalid_q, debug_req_q, debug_req_d;
  logic [31:0]         rdata_q, rdata_d, rd_val;
  logic                set_done, set_to;

  logic [1:0] reg_sel;
  logic       wr_en, wr_ctrl, wr_start, wr_dur, wr_stat, arm, abort;
  logic       unused_addr;

  assign reg_sel     = addr_i[3:2];
  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};
  assign wr_en       = req_i & we_i;
  assign wr_ctrl     = wr_en & (reg_sel == 2'd0) & be_i[0];
  assign wr_start    = wr_en & (reg_sel == 2'd1);
  assign wr_dur      = wr_en & (reg_sel == 2'd2);
  assign wr_stat     = wr_en & (reg_sel == 2'd3) & be_i[0];
  assign arm         = wr_ctrl & wdata_i[0];
  assign abort       = wr_ctrl & wdata_i[1];

  function automatic logic [CntWidth-1:0] merge_bytes(input logic [CntWidth-1:0] cur,
                                                      input logic [31:0] wd,
                                                      input logic [3:0] be);
    logic [31:0] ext;
    ext = 32'(cur);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ext[8*b +: 8] = wd[8*b +: 8];
    end
    return ext[CntWidth-1:0];
  endfunction

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0:    rd_val = {28'b0, ie_q, pass_dm_q, 2'b00};
      2'd1:    rd_val = 32'(start_q);
      2'd2:    rd_val = 32'(duration_q);
      default: rd_val = {28'b0, timeout_q, done_q, state_q};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    set_done = 1'b0;
    set_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_DELAY;
          cnt_d   = start_q;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      ST_ASSERT: begin
        if (core_debug_mode_i) begin
          state_d = ST_HOLD;
          cnt_d   = duration_q;
        end else if (cnt_q == AckLast) begin
          state_d = ST_IDLE;
          set_to  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          set_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides both arm and any completion in the same cycle.
    if (abort) begin
      state_d  = ST_IDLE;
      set_done = 1'b0;
      set_to   = 1'b0;
    end
  end

  always_comb begin
    start_d     = wr_start ? merge_bytes(start_q, wdata_i, be_i) : start_q;
    duration_d  = wr_dur ? merge_bytes(duration_q, wdata_i, be_i) : duration_q;
    pass_dm_d   = wr_ctrl ? wdata_i[2] : pass_dm_q;
    done_d      = (done_q & ~(wr_stat & wdata_i[2])) | set_done;
    timeout_d   = (timeout_q & ~(wr_stat & wdata_i[3])) | set_to;
    rdata_d     = (req_i & ~we_i) ? rd_val : 32'h0;
    debug_req_d = (pass_dm_q & dm_debug_req_i) | (state_q == ST_ASSERT) | (state_q == ST_HOLD);
  end

  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      start_q     <= '0;
      duration_q  <= '0;
      pass_dm_q   <= 1'b1;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      debug_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      duration_q  <= duration_d;
      pass_dm_q   <= pass_dm_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      rvalid_q    <= req_i;
      rdata_q     <= rdata_d;
      debug_req_q <= debug_req_d;
    end
  end

`ifdef DBG_HALT_SCHED_IRQ_EN
  logic irq_q;

  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= wdata_i[3];
      irq_q <= ie_q & (done_q | timeout_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign ie_q = 1'b0;
`endif

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign debug_req_o = debug_req_q;

endmodule

// File: tb/tb_dbg_halt_sched.sv
// Directed self-checking bench for dbg_halt_sched; bus reads go through an expected-value queue.
module tb_dbg_halt_sched;
  logic        IO_CLK = 1'b0;
  logic        IO_RST_N = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        dm_debug_req_i = 1'b0;
  logic        core_debug_mode_i = 1'b0;
  logic        debug_req_o;
`ifdef DBG_HALT_SCHED_IRQ_EN
  logic        irq_o;
`endif

  dbg_halt_sched dut (
    .IO_CLK            (IO_CLK),
    .IO_RST_N          (IO_RST_N),
    .req_i             (req_i),
    .we_i              (we_i),
    .be_i              (be_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .rvalid_o          (rvalid_o),
    .rdata_o           (rdata_o),
    .dm_debug_req_i    (dm_debug_req_i),
    .core_debug_mode_i (core_debug_mode_i),
`ifdef DBG_HALT_SCHED_IRQ_EN
    .irq_o             (irq_o),
`endif
    .debug_req_o       (debug_req_o)
  );

  always #5 IO_CLK = ~IO_CLK;

  int          checks = 0;
  int          errors = 0;
  int          k;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic bus_op(input string tag, input logic we, input logic [1:0] ra,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
    logic [31:0] want;
    req_i   = 1'b1;
    we_i    = we;
    be_i    = be;
    addr_i  = {28'h0, ra, 2'b00};
    wdata_i = wd;
    exp_q.push_back(we ? 32'h0 : exp);
    @(posedge IO_CLK);
    @(negedge IO_CLK);
    req_i = 1'b0;
    we_i  = 1'b0;
    be_i  = 4'h0;
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'h1);
    want = exp_q.pop_front();
    chk({tag, "_rdata"}, rdata_o, want);
  endtask

  task automatic rd(input string tag, input logic [1:0] ra, input logic [31:0] exp);
    bus_op(tag, 1'b0, ra, 4'hF, 32'h0, exp);
  endtask

  task automatic wr(input string tag, input logic [1:0] ra, input logic [3:0] be, input logic [31:0] wd);
    bus_op(tag, 1'b1, ra, be, wd, 32'h0);
  endtask

  // Number of negedges until debug_req_o equals level; max+1 if it never does.
  task automatic wait_dbg(input logic level, input int max, output int n);
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      @(negedge IO_CLK);
      if (debug_req_o === level) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge IO_CLK);
    chk("rst_dbg_req", 32'(debug_req_o), 32'h0);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    IO_RST_N = 1'b1;
    @(negedge IO_CLK);

    rd("rst_ctrl", 2'd0, 32'h4);
    rd("rst_start", 2'd1, 32'h0);
    rd("rst_dur", 2'd2, 32'h0);
    rd("rst_status", 2'd3, 32'h0);
    @(negedge IO_CLK);
    chk("rvalid_one_cycle", 32'(rvalid_o), 32'h0);
    chk("idle_dbg_req", 32'(debug_req_o), 32'h0);

    wr("ctrl_all", 2'd0, 4'h1, 32'hF);
`ifdef DBG_HALT_SCHED_IRQ_EN
    rd("ctrl_rb", 2'd0, 32'hC);
`else
    rd("ctrl_rb", 2'd0, 32'h4);
`endif
    wr("ctrl_restore", 2'd0, 4'h1, 32'h4);

    // Timed halt with ack two cycles after debug_req rises.
    wr("start5", 2'd1, 4'hF, 32'd5);
    wr("dur3", 2'd2, 4'hF, 32'd3);
    wr("arm", 2'd0, 4'h1, 32'h5);
    wait_dbg(1'b1, 20, k);
    chk("rise_latency", 32'(k), 32'd7);
    repeat (2) @(negedge IO_CLK);
    core_debug_mode_i = 1'b1;
    wait_dbg(1'b0, 40, k);
    chk("hold_fall", 32'(k), 32'd6);
    core_debug_mode_i = 1'b0;
    rd("done_status", 2'd3, 32'h4);
    wr("done_clr", 2'd3, 4'h1, 32'h4);
    rd("done_cleared", 2'd3, 32'h0);

    // Ack timeout.
    wr("start0", 2'd1, 4'hF, 32'd0);
    wr("arm_to", 2'd0, 4'h1, 32'h5);
    wait_dbg(1'b1, 10, k);
    chk("to_rise", 32'(k), 32'd2);
    wait_dbg(1'b0, 1100, k);
    chk("to_assert_cycles", 32'(k), 32'd1024);
    rd("to_status", 2'd3, 32'h8);
    wr("to_clr", 2'd3, 4'h1, 32'h8);
    rd("to_cleared", 2'd3, 32'h0);

    // Abort during DELAY, and ABORT+ARM together.
    wr("start20", 2'd1, 4'hF, 32'd20);
    wr("arm_ab", 2'd0, 4'h1, 32'h5);
    rd("delay_status", 2'd3, 32'h1);
    wr("abort_delay", 2'd0, 4'h1, 32'h6);
    rd("abort_delay_st", 2'd3, 32'h0);
    chk("abort_delay_dbg", 32'(debug_req_o), 32'h0);
    wr("arm_abort", 2'd0, 4'h1, 32'h7);
    rd("arm_abort_st", 2'd3, 32'h0);

    // Abort during HOLD.
    wr("start0b", 2'd1, 4'hF, 32'd0);
    wr("dur50", 2'd2, 4'hF, 32'd50);
    wr("arm_hold", 2'd0, 4'h1, 32'h5);
    wait_dbg(1'b1, 10, k);
    chk("hold_rise", 32'(k), 32'd2);
    core_debug_mode_i = 1'b1;
    repeat (3) @(negedge IO_CLK);
    rd("hold_status", 2'd3, 32'h3);
    wr("abort_hold", 2'd0, 4'h1, 32'h6);
    chk("abort_hold_dbg_hi", 32'(debug_req_o), 32'h1);
    @(negedge IO_CLK);
    chk("abort_hold_dbg_lo", 32'(debug_req_o), 32'h0);
    core_debug_mode_i = 1'b0;
    rd("abort_hold_st", 2'd3, 32'h0);

    // DM pass-through.
    dm_debug_req_i = 1'b1;
    @(negedge IO_CLK);
    chk("dm_pass", 32'(debug_req_o), 32'h1);
    wr("pass_off", 2'd0, 4'h1, 32'h0);
    chk("pass_off_lag", 32'(debug_req_o), 32'h1);
    @(negedge IO_CLK);
    chk("pass_off_dbg", 32'(debug_req_o), 32'h0);
    dm_debug_req_i = 1'b0;
    wr("pass_on", 2'd0, 4'h1, 32'h4);

    // Byte enables.
    wr("start_b1", 2'd1, 4'b0010, 32'hAABBCCDD);
    rd("start_b1_rb", 2'd1, 32'h0000CC00);
    wr("dur_b03", 2'd2, 4'b1001, 32'h11223344);
    rd("dur_b03_rb", 2'd2, 32'h11000044);

`ifdef DBG_HALT_SCHED_IRQ_EN
    wr("irq_ie", 2'd0, 4'h1, 32'hC);
    wr("irq_start", 2'd1, 4'hF, 32'd0);
    wr("irq_dur", 2'd2, 4'hF, 32'd0);
    chk("irq_idle", 32'(irq_o), 32'h0);
    core_debug_mode_i = 1'b1;
    wr("irq_arm", 2'd0, 4'h1, 32'hD);
    repeat (6) @(negedge IO_CLK);
    core_debug_mode_i = 1'b0;
    chk("irq_set", 32'(irq_o), 32'h1);
    wr("irq_clr", 2'd3, 4'h1, 32'h4);
    chk("irq_lag", 32'(irq_o), 32'h1);
    @(negedge IO_CLK);
    chk("irq_cleared", 32'(irq_o), 32'h0);
    wr("irq_ie_off", 2'd0, 4'h1, 32'h4);
`endif

    // Reset mid-operation.
    wr("start100", 2'd1, 4'hF, 32'd100);
    wr("arm_rst", 2'd0, 4'h1, 32'h5);
    wait_dbg(1'b1, 200, k);
    chk("long_rise", 32'(k), 32'd102);
    #2 IO_RST_N = 1'b0;
    #1;
    chk("async_rst_dbg", 32'(debug_req_o), 32'h0);
    @(negedge IO_CLK);
    IO_RST_N = 1'b1;
    rd("post_rst_start", 2'd1, 32'h0);
    rd("post_rst_status", 2'd3, 32'h0);
    rd("post_rst_ctrl", 2'd0, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
